pipelined_adder: RTL and testbench

//   Parametrised, pipelined successor to the single-bit full adder: a WIDTH-bit add/subtract

---
 rtl/pipelined_adder_pkg.sv | 9 +
 rtl/pipelined_adder_slice.sv | 23 ++
 rtl/pipelined_adder.sv | 161 ++++++++++++++++
 tb/tb_pipelined_adder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared types for the pipelined add/subtract unit.
package pipelined_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/pipelined_adder_slice.sv
// Combinational W-bit slice adder; also reports the carry into its MSB for overflow detection.
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] full_s;

  // One wide add; the carry into the MSB is recovered from the MSB sum bit and its operands.
  always_comb begin
    full_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    sum    = full_s[W-1:0];
    co     = full_s[W];
    c_msb  = full_s[W-1] ^ a[W-1] ^ b[W-1];
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract unit rippling carry across STAGE_W-bit slices, one slice per
// pipeline stage, with a valid/ready stream interface and a global stall.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STAGE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  input  op_e              in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf
);

  localparam int SW_SAFE = (STAGE_W < 1) ? 1 : STAGE_W;
  localparam int STAGES  = WIDTH / SW_SAFE;

  if ((STAGE_W < 1) || ((WIDTH % SW_SAFE) != 0)) begin : g_bad_cfg
    $fatal(1, "pipelined_adder: STAGE_W must be >= 1 and divide WIDTH");
  end

  logic             en_s;
  logic             accept_s;
  logic [WIDTH-1:0] a_eff_s;
  logic [WIDTH-1:0] b_eff_s;
  logic             ci_eff_s;

  assign en_s     = !out_valid || out_ready;
  assign in_ready = en_s;
  assign accept_s = in_valid && en_s;

  // Operand entry: SUB inverts B and the borrow; idle beats are forced to zero so X never propagates.
  always_comb begin
    a_eff_s  = {WIDTH{1'b0}};
    b_eff_s  = {WIDTH{1'b0}};
    ci_eff_s = 1'b0;
    if (accept_s) begin
      a_eff_s = in_a;
      if (in_op == OP_SUB) begin
        b_eff_s  = ~in_b;
        ci_eff_s = ~in_ci;
      end else begin
        b_eff_s  = in_b;
        ci_eff_s = in_ci;
      end
    end else begin
      a_eff_s  = {WIDTH{1'b0}};
      b_eff_s  = {WIDTH{1'b0}};
      ci_eff_s = 1'b0;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * STAGE_W;

    logic                v_r;
    logic [DONE-1:0]     sum_r;
    logic                co_r;
    logic [STAGE_W-1:0]  sa_s;
    logic [STAGE_W-1:0]  sb_s;
    logic [STAGE_W-1:0]  ss_s;
    logic                sci_s;
    logic                sco_s;
    logic                scm_s;
    logic                v_in_s;
    logic [DONE-1:0]     sum_nxt_s;

    // Stage 0 reads the entry operands; later stages read the operands carried by their predecessor.
    if (k == 0) begin : g_in
      assign sa_s      = a_eff_s[STAGE_W-1:0];
      assign sb_s      = b_eff_s[STAGE_W-1:0];
      assign sci_s     = ci_eff_s;
      assign v_in_s    = accept_s;
      assign sum_nxt_s = ss_s;
    end else begin : g_in
      assign sa_s      = g_stage[k-1].g_ops.a_r[STAGE_W-1:0];
      assign sb_s      = g_stage[k-1].g_ops.b_r[STAGE_W-1:0];
      assign sci_s     = g_stage[k-1].co_r;
      assign v_in_s    = g_stage[k-1].v_r;
      assign sum_nxt_s = {ss_s, g_stage[k-1].sum_r};
    end

    adder_slice #(.W(STAGE_W)) u_slice (
      .a     (sa_s),
      .b     (sb_s),
      .ci    (sci_s),
      .sum   (ss_s),
      .co    (sco_s),
      .c_msb (scm_s)
    );

    // Stage valid, finished low sum slices and ripple carry; everything holds while stalled.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_r   <= 1'b0;
        sum_r <= {DONE{1'b0}};
        co_r  <= 1'b0;
      end else if (en_s) begin
        v_r   <= v_in_s;
        sum_r <= sum_nxt_s;
        co_r  <= sco_s;
      end
    end

    // Only the upper, still-unprocessed operand slices travel down the pipe.
    if (k < STAGES - 1) begin : g_ops
      localparam int REM = WIDTH - DONE;
      logic [REM-1:0] a_r;
      logic [REM-1:0] b_r;
      logic [REM-1:0] a_nxt_s;
      logic [REM-1:0] b_nxt_s;

      if (k == 0) begin : g_src
        assign a_nxt_s = a_eff_s[WIDTH-1:STAGE_W];
        assign b_nxt_s = b_eff_s[WIDTH-1:STAGE_W];
      end else begin : g_src
        assign a_nxt_s = g_stage[k-1].g_ops.a_r[REM+STAGE_W-1:STAGE_W];
        assign b_nxt_s = g_stage[k-1].g_ops.b_r[REM+STAGE_W-1:STAGE_W];
      end

      // Pending operand slices for the stages downstream.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_r <= {REM{1'b0}};
          b_r <= {REM{1'b0}};
        end else if (en_s) begin
          a_r <= a_nxt_s;
          b_r <= b_nxt_s;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_r;

      // Signed overflow is captured alongside the final carry so the output stays registered.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (en_s) begin
          ovf_r <= sco_s ^ scm_s;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_r;
  assign out_sum   = g_stage[STAGES-1].sum_r;
  assign out_co    = g_stage[STAGES-1].co_r;
  assign out_ovf   = g_stage[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: 4-stage instance for most traffic, 1-stage instance for the degenerate case.
module tb_pipelined_adder;
  import pipelined_adder_pkg::*;

  localparam int STAGES = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_ci, out_valid, out_ready, out_co, out_ovf;
  logic [31:0] in_a, in_b, out_sum;
  op_e         in_op;

  logic        in_valid1, in_ready1, in_ci1, out_valid1, out_ready1, out_co1, out_ovf1;
  logic [31:0] in_a1, in_b1, out_sum1;
  op_e         in_op1;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(32), .STAGE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_co(out_co), .out_ovf(out_ovf)
  );

  pipelined_adder #(.WIDTH(32), .STAGE_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_ci(in_ci1), .in_op(in_op1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
    .out_co(out_co1), .out_ovf(out_ovf1)
  );

  typedef struct {
    logic [31:0] sum;
    logic        co;
    logic        ovf;
    int          pcyc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   npop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, expv, $time);
    end
  endtask

  // Reference: unsigned carry/borrow from a wide add, overflow from a signed range check.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic ci,
                                 input op_e op, input bit lat);
    exp_t        e;
    longint      sr;
    logic [32:0] u;
    if (op == OP_ADD) begin
      u     = {1'b0, a} + {1'b0, b} + {32'b0, ci};
      e.sum = u[31:0];
      e.co  = u[32];
      sr    = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
    end else begin
      e.sum = a - b - {31'b0, ci};
      e.co  = ({1'b0, a} >= ({1'b0, b} + {32'b0, ci}));
      sr    = longint'($signed(a)) - longint'($signed(b)) - longint'(ci);
    end
    e.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.pcyc = cyc;
    e.lat  = lat;
    return e;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci,
                      input op_e op, input bit lat);
    in_a = a; in_b = b; in_ci = ci; in_op = op; in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(a, b, ci, op, lat));
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Output side: pop the scoreboard on every handshake, and check that stalls block input.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        npop++;
        check("sum", 64'(out_sum), 64'(mon_e.sum));
        check("co", 64'(out_co), 64'(mon_e.co));
        check("ovf", 64'(out_ovf), 64'(mon_e.ovf));
        if (mon_e.lat) check("latency", 64'(cyc - mon_e.pcyc), 64'(STAGES));
      end
    end
    if (rst_n && out_valid && !out_ready) check("in_ready_stall", 64'(in_ready), 64'd0);
  end

  bit rdone;
  int base;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = 32'd0; in_b = 32'd0; in_ci = 1'b0; in_op = OP_ADD;
    in_valid1 = 1'b0; out_ready1 = 1'b1;
    in_a1 = 32'd0; in_b1 = 32'd0; in_ci1 = 1'b0; in_op1 = OP_ADD;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_co", 64'(out_co), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid1", 64'(out_valid1), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full carry ripple, signed overflow, stage-0 to stage-1 carry.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 1'b1);
    drain();
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 1'b1);
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, OP_ADD, 1'b1);
    drain();

    // Subtraction incl. borrow-in and overflow.
    send(32'd5, 32'd7, 1'b0, OP_SUB, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB, 1'b1);
    send(32'd10, 32'd3, 1'b1, OP_SUB, 1'b1);
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, OP_ADD, 1'b1);
    drain();

    // Back-to-back stream with a 3-cycle output stall.
    base = npop;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(32'h1111_1111 * i + 32'h00FF_00FF, 32'hF0F0_0F0F ^ i, i[0], OP_ADD, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", 64'(npop - base), 64'd8);

    // Reset with three beats in flight: nothing may emerge afterwards.
    send(32'd1, 32'd2, 1'b0, OP_ADD, 1'b0);
    send(32'd3, 32'd4, 1'b0, OP_ADD, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, OP_ADD, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_co", 64'(out_co), 64'd0);
    check("midrst_out_ovf", 64'(out_ovf), 64'd0);
    check("midrst_out_sum", 64'(out_sum), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Random ops with random backpressure.
    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          send($urandom, $urandom, 1'($urandom_range(0, 1)), op_e'($urandom_range(0, 1)), 1'b0);
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Single-stage instance: registered adder, result one cycle after acceptance.
    in_a1 = 32'd3; in_b1 = 32'd4; in_ci1 = 1'b1; in_op1 = OP_ADD; in_valid1 = 1'b1;
    @(negedge clk);
    check("s1_in_ready", 64'(in_ready1), 64'd1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    check("s1_out_valid", 64'(out_valid1), 64'd1);
    check("s1_sum", 64'(out_sum1), 64'd8);
    check("s1_co", 64'(out_co1), 64'd0);
    @(negedge clk);
    check("s1_drained", 64'(out_valid1), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
